mole_game_ctrl: RTL and testbench
=================================

MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 SHALL have parameter MOLE_TIME, default 16: cycles a mole stays lit (legal range 2..65535).
REQ-002 SHALL have parameter GAP_TIME, default 4: dark cycles between moles (legal range 1..65535).
REQ-003 SHALL have parameter ROUNDS, default 10: moles per game (legal range 1..255).
REQ-004 SHALL have parameter LIVES, default 3: misses allowed before game over (legal range 1..3).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: level-sampled request to begin a game.
REQ-008 SHALL have port btn, input, 8 bits: debounced button levels, bit i = hole i.
REQ-009 SHALL have port rnd, input, 8 bits: free-running RNG value; only rnd[2:0] is used.
REQ-010 SHALL have port led, output, 8 bits: one-hot lit mole, or all zero.
REQ-011 SHALL have port score, output, 8 bits: hit count.
REQ-012 SHALL have port lives, output, 2 bits: remaining lives.
REQ-013 SHALL have port busy, output, 1 bit: high when the state is neither IDLE nor OVER.
REQ-014 SHALL have port game_over, output, 1 bit: high while the state is OVER.

Function
REQ-015 SHALL implement FSM states IDLE, GAP, SHOW, HIT, MISS and OVER; all outputs SHALL be registered.
REQ-016 SHALL register btn every cycle as btn_q and derive press = btn & ~btn_q; only rising edges count.
REQ-017 IDLE or OVER with start=1 SHALL clear score and round to 0, load lives=LIVES, clear the timer and go to GAP; start SHALL be ignored in all other states.
REQ-018 GAP SHALL hold led=0 for exactly GAP_TIME cycles, then go to SHOW.
REQ-019 On the GAP->SHOW edge, mole index m SHALL be rnd[2:0], except when rnd[2:0] equals the previous index, in which case m SHALL be (prev+1) mod 8; led SHALL be set to 1<<m on that same edge.
REQ-020 SHOW with press[m]=1 SHALL go to HIT; the hit SHALL take priority over other pressed bits and over timeout in the same cycle.
REQ-021 SHOW with press!=0 and press[m]=0 SHALL go to MISS (wrong hole).
REQ-022 SHOW with no press SHALL go to MISS after MOLE_TIME cycles.
REQ-023 HIT SHALL last one cycle: led=0, score incremented and saturating at 255, round incremented.
REQ-024 MISS SHALL last one cycle: led=0, lives decremented and saturating at 0, round incremented.
REQ-025 From HIT or MISS, the next state SHALL be OVER if lives==0 after the update or round==ROUNDS after the update; otherwise it SHALL be GAP.
REQ-026 In OVER, led SHALL be 0, and score and lives SHALL hold until the next start.
REQ-027 The timer SHALL be 16 bits, reset on every state entry, and SHALL never wrap within a state.
REQ-028 A button already held when SHOW is entered SHALL NOT register as a press until it is released and pressed again.

Reset
REQ-029 reset=0 SHALL asynchronously force state=IDLE, led=0, score=0, lives=0, busy=0, game_over=0, btn_q=0, timer=0, round=0 and prev index=0.
REQ-030 Reset asserted mid-game SHALL abandon the game with no score or lives update; after release the block SHALL wait in IDLE for start.
REQ-031 Reset release SHALL take effect on the first rising clk edge after reset goes high.

Verification
REQ-032 Bench SHALL cover reset then start pulse, rnd=8'h05: led=0 for 4 cycles, then led=8'h20; busy=1, lives=3.
REQ-033 Bench SHALL cover btn[5] rising during SHOW with mole 5: HIT, score=1, then GAP; a second mole with rnd[2:0]=5 SHALL light led=8'h40.
REQ-034 Bench SHALL cover btn[2] rising plus btn[5] rising in the same cycle, mole 5: HIT, no life lost.
REQ-035 Bench SHALL cover three moles with no press: each SHALL stay lit exactly 16 cycles; lives goes 3->2->1->0, then game_over=1, busy=0, led=0.
REQ-036 Bench SHALL cover ten hits in a row: score=10, game_over=1; start in OVER SHALL restart with score=0, lives=3.
REQ-037 Bench SHALL cover reset low during SHOW with score=4: all outputs zero immediately, state IDLE; btn held high from before SHOW SHALL NOT produce a hit.

Source files
------------

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: paces lit moles and dark gaps, scores rising-edge
// button hits against the lit hole, and tracks lives and rounds until game over.
module mole_game_ctrl #(
    parameter int unsigned MOLE_TIME = 16,
    parameter int unsigned GAP_TIME  = 4,
    parameter int unsigned ROUNDS    = 10,
    parameter int unsigned LIVES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] btn,
    input  logic [7:0] rnd,
    output logic [7:0] led,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        SHOW,
        HIT,
        MISS,
        OVER
    } state_t;

    localparam logic [15:0] GAP_LAST  = 16'(GAP_TIME - 1);
    localparam logic [15:0] MOLE_LAST = 16'(MOLE_TIME - 1);
    localparam logic [7:0]  ROUNDS_L  = 8'(ROUNDS);
    localparam logic [1:0]  LIVES_L   = 2'(LIVES);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  round_q, round_d;
    logic [2:0]  prev_q, prev_d;
    logic [7:0]  btn_q, btn_d;
    logic [7:0]  led_q, led_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic        busy_q, busy_d;
    logic        game_over_q, game_over_d;

    logic [7:0]  press;
    logic [2:0]  pick;
    logic        unused_rnd;

    assign unused_rnd = ^rnd[7:3];
    assign press      = btn & ~btn_q;
    // Never repeat the same hole twice in a row.
    assign pick       = (rnd[2:0] == prev_q) ? prev_q + 3'd1 : rnd[2:0];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        round_d = round_q;
        prev_d  = prev_q;
        btn_d   = btn;
        led_d   = led_q;
        score_d = score_q;
        lives_d = lives_q;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d = GAP;
                    timer_d = '0;
                    score_d = '0;
                    round_d = '0;
                    lives_d = LIVES_L;
                    led_d   = '0;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = SHOW;
                    timer_d = '0;
                    prev_d  = pick;
                    led_d   = 8'd1 << pick;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            SHOW: begin
                // prev_q holds the lit hole for the whole SHOW phase.
                if (press[prev_q]) begin
                    state_d = HIT;
                    timer_d = '0;
                    led_d   = '0;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    round_d = round_q + 8'd1;
                end else if (press != 8'd0 || timer_q == MOLE_LAST) begin
                    state_d = MISS;
                    timer_d = '0;
                    led_d   = '0;
                    lives_d = (lives_q == 2'd0) ? lives_q : lives_q - 2'd1;
                    round_d = round_q + 8'd1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            HIT, MISS: begin
                timer_d = '0;
                state_d = (lives_q == 2'd0 || round_q == ROUNDS_L) ? OVER : GAP;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                led_d   = '0;
            end
        endcase

        busy_d      = (state_d != IDLE) && (state_d != OVER);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            round_q     <= '0;
            prev_q      <= '0;
            btn_q       <= '0;
            led_q       <= '0;
            score_q     <= '0;
            lives_q     <= '0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            round_q     <= round_d;
            prev_q      <= prev_d;
            btn_q       <= btn_d;
            led_q       <= led_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign led       = led_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: countdown-style game model compared every cycle,
// directed game scenarios with literal expectations, then randomized play.
module tb_mole_game_ctrl;

    localparam int MOLE_T  = 16;
    localparam int GAP_T   = 4;
    localparam int NROUNDS = 10;
    localparam int NLIVES  = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] btn;
    logic [7:0] rnd;
    logic [7:0] led;
    logic [7:0] score;
    logic [1:0] lives;
    logic       busy;
    logic       game_over;

    int   n_vec  = 0;
    int   n_err  = 0;
    logic chk_en = 1'b0;

    mole_game_ctrl #(
        .MOLE_TIME(MOLE_T),
        .GAP_TIME (GAP_T),
        .ROUNDS   (NROUNDS),
        .LIVES    (NLIVES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .btn      (btn),
        .rnd      (rnd),
        .led      (led),
        .score    (score),
        .lives    (lives),
        .busy     (busy),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game model: a game is "playing"; it is either counting down dark cycles,
    // counting down lit cycles, or settling one cycle after a hit/miss.
    bit         m_play, m_over;
    int         m_dark, m_lit, m_score, m_lives, m_rounds, m_prev, m_mole;
    logic [7:0] m_led, m_btn, m_press;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_play = 0; m_over = 0; m_dark = 0; m_lit = 0;
            m_score = 0; m_lives = 0; m_rounds = 0; m_prev = 0; m_mole = 0;
            m_led = 8'h00; m_btn = 8'h00;
        end else begin
            m_press = btn & ~m_btn;
            m_btn   = btn;
            if (!m_play) begin
                if (start) begin
                    m_play = 1; m_over = 0; m_score = 0; m_lives = NLIVES;
                    m_rounds = 0; m_dark = GAP_T; m_led = 8'h00;
                end
            end else if (m_dark != 0) begin
                m_dark = m_dark - 1;
                if (m_dark == 0) begin
                    m_mole = (int'(rnd[2:0]) == m_prev) ? (m_prev + 1) % 8 : int'(rnd[2:0]);
                    m_prev = m_mole;
                    m_led  = 8'h01 << m_mole;
                    m_lit  = MOLE_T;
                end
            end else if (m_lit != 0) begin
                if (m_press[m_mole]) begin
                    if (m_score < 255) m_score = m_score + 1;
                    m_rounds = m_rounds + 1; m_lit = 0; m_led = 8'h00;
                end else if (m_press != 8'h00 || m_lit == 1) begin
                    if (m_lives > 0) m_lives = m_lives - 1;
                    m_rounds = m_rounds + 1; m_lit = 0; m_led = 8'h00;
                end else begin
                    m_lit = m_lit - 1;
                end
            end else begin
                if (m_lives == 0 || m_rounds == NROUNDS) begin
                    m_play = 0; m_over = 1;
                end else begin
                    m_dark = GAP_T;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (led !== m_led || score !== 8'(m_score) || lives !== 2'(m_lives) ||
                busy !== m_play || game_over !== m_over) begin
                n_err++;
                $display("FAIL model t=%0t: got led=%h score=%0d lives=%0d busy=%b over=%b, want led=%h score=%0d lives=%0d busy=%b over=%b",
                         $time, led, score, lives, busy, game_over,
                         m_led, m_score, m_lives, m_play, m_over);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input logic s, input logic [7:0] b, input logic [7:0] r);
        start = s; btn = b; rnd = r;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lit(input string name);
        int k = 0;
        while (led == 8'h00 && k < 40) begin
            step(1'b0, 8'h00, 8'($urandom));
            k++;
        end
        if (k == 40) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic run_miss(input int exp_lives);
        int lit = 0;
        wait_lit("miss_wait");
        while (led != 8'h00 && lit < 40) begin
            step(1'b0, 8'h00, 8'($urandom));
            lit++;
        end
        check("lit_cycles", lit, 16);
        check("lives_after_miss", int'(lives), exp_lives);
    endtask

    initial begin
        logic [7:0] b;
        reset = 1'b1; start = 1'b0; btn = 8'h00; rnd = 8'h00;
        #2 reset = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_led", int'(led), 0);
        check("rst_score", int'(score), 0);
        check("rst_lives", int'(lives), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_over", int'(game_over), 0);
        #9 reset = 1'b1;
        step(1'b0, 8'h00, 8'h05);
        step(1'b0, 8'h00, 8'h05);
        check("idle_busy", int'(busy), 0);

        // First mole from rnd=5 after four dark cycles.
        step(1'b1, 8'h00, 8'h05);
        check("start_busy", int'(busy), 1);
        check("start_lives", int'(lives), 3);
        check("gap_led0", int'(led), 0);
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 8'h00, 8'h05);
            check("gap_led", int'(led), 0);
        end
        step(1'b0, 8'h00, 8'h05);
        check("mole5_led", int'(led), 8'h20);

        // Hit on hole 5, then repeated rnd=5 moves to hole 6.
        step(1'b0, 8'h20, 8'h05);
        check("hit5_score", int'(score), 1);
        check("hit5_led", int'(led), 0);
        step(1'b0, 8'h00, 8'h05);
        check("hit5_busy", int'(busy), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h05);
        check("mole6_led", int'(led), 8'h40);
        step(1'b0, 8'h40, 8'h05);
        check("hit6_score", int'(score), 2);

        // Correct and wrong hole pressed together: the hit wins.
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 8'h05);
        check("mole5b_led", int'(led), 8'h20);
        step(1'b0, 8'h24, 8'h05);
        check("dual_score", int'(score), 3);
        check("dual_lives", int'(lives), 3);

        // Score 4, then hold hole 3 across the mole's appearance and reset mid-SHOW.
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 8'h01);
        check("mole1_led", int'(led), 8'h02);
        step(1'b0, 8'h02, 8'h01);
        check("hit1_score", int'(score), 4);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h08, 8'h03);
        check("mole3_led", int'(led), 8'h08);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h08, 8'h03);
        check("held_no_hit", int'(score), 4);
        check("held_led", int'(led), 8'h08);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_led", int'(led), 0);
        check("mid_rst_score", int'(score), 0);
        check("mid_rst_lives", int'(lives), 0);
        check("mid_rst_busy", int'(busy), 0);
        #3 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h08, 8'h03);
            check("post_rst_idle", int'({busy, game_over, led}), 0);
        end

        // Three timeouts end the game.
        step(1'b1, 8'h00, 8'($urandom));
        run_miss(2);
        run_miss(1);
        run_miss(0);
        step(1'b0, 8'h00, 8'h00);
        check("miss_over", int'(game_over), 1);
        check("miss_busy", int'(busy), 0);
        check("miss_led", int'(led), 0);

        // Restart from OVER and win all ten rounds.
        step(1'b1, 8'h00, 8'($urandom));
        check("restart_score", int'(score), 0);
        check("restart_lives", int'(lives), 3);
        check("restart_over", int'(game_over), 0);
        for (int i = 0; i < NROUNDS; i++) begin
            wait_lit("hit_wait");
            b = led;
            step(1'b0, b, 8'($urandom));
            check("streak_score", int'(score), i + 1);
        end
        step(1'b0, 8'h00, 8'h00);
        check("win_over", int'(game_over), 1);
        check("win_score", int'(score), 10);
        step(1'b1, 8'h00, 8'h00);
        check("win_restart_score", int'(score), 0);
        check("win_restart_lives", int'(lives), 3);

        // Randomized play with occasional restarts and async resets.
        b = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'h00;
                2:       b = led;
                3:       b = 8'($urandom);
                default: ;
            endcase
            step(($urandom_range(0, 15) == 0), b, 8'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
